// File: rtl/config_loader_if.sv
// Bitstream handshake, config-chain and fabric-control signals of config_loader.
// The master side is the host plus the chain tail; the slave side is the controller.
interface config_loader_if #(
    parameter int unsigned WORD_WIDTH = 8
);
    logic                  en;
    logic                  start;
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;
    logic                  config_data_in;
    logic                  config_en;
    logic                  config_data_out;
    logic                  le_en;
    logic                  le_nrst;
    logic                  busy;
    logic                  done;
    logic                  tail_parity;

    modport master (
        output en, start, word_in, word_valid, config_data_out,
        input  word_ready, config_data_in, config_en, le_en, le_nrst, busy, done, tail_parity
    );

    modport slave (
        input  en, start, word_in, word_valid, config_data_out,
        output word_ready, config_data_in, config_en, le_en, le_nrst, busy, done, tail_parity
    );
endinterface

// File: rtl/config_loader.sv
// Serialises a word-packed bitstream MSB-first onto a config shift chain, then
// pulses the fabric reset. Outputs are registered; en=0 freezes every register.
module config_loader #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CHAIN_LEN  = 17,
    parameter int unsigned RST_CYCLES = 2
) (
    input logic            i_clk,
    input logic            i_nrst,
    config_loader_if.slave io_bus
);
    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned SbW  = $clog2(WORD_WIDTH + 1);
    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StFabricRst, StDone} state_e;

    state_e                r_state;
    logic [WORD_WIDTH-1:0] r_sbuf;
    logic [SbW-1:0]        r_sbuf_cnt;
    logic [CntW-1:0]       r_bit_cnt;
    logic [RstW-1:0]       r_rst_cnt;
    logic                  r_cfg_en;
    logic                  r_cfg_din;
    logic                  r_word_ready;
    logic                  r_le_en;
    logic                  r_le_nrst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_tail_parity;

    logic            w_shift;
    logic            w_take;
    logic            w_more;
    logic [CntW-1:0] w_bit_cnt_nxt;

    // r_sbuf holds bits not yet presented; the presented bit lives in r_cfg_din.
    assign w_shift       = r_cfg_en;
    assign w_take        = r_word_ready & io_bus.word_valid;
    assign w_bit_cnt_nxt = r_bit_cnt + CntW'(w_shift);
    assign w_more        = w_bit_cnt_nxt < CntW'(CHAIN_LEN - 1);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state       <= StIdle;
            r_sbuf        <= '0;
            r_sbuf_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_rst_cnt     <= '0;
            r_cfg_en      <= 1'b0;
            r_cfg_din     <= 1'b0;
            r_word_ready  <= 1'b0;
            r_le_en       <= 1'b0;
            r_le_nrst     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tail_parity <= 1'b0;
        end else if (io_bus.en) begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_state       <= StLoad;
                        r_busy        <= 1'b1;
                        r_word_ready  <= 1'b1;
                        r_tail_parity <= 1'b0;
                        r_bit_cnt     <= '0;
                        r_sbuf_cnt    <= '0;
                        r_cfg_en      <= 1'b0;
                        r_le_en       <= 1'b0;
                        r_le_nrst     <= 1'b0;
                    end
                end
                StLoad: begin
                    // Tail bit is sampled before the chain shifts on this edge.
                    if (w_shift) r_tail_parity <= r_tail_parity ^ io_bus.config_data_out;
                    r_bit_cnt <= w_bit_cnt_nxt;
                    if (w_bit_cnt_nxt == CntW'(CHAIN_LEN)) begin
                        r_state      <= StFabricRst;
                        r_cfg_en     <= 1'b0;
                        r_cfg_din    <= 1'b0;
                        r_word_ready <= 1'b0;
                        r_le_en      <= 1'b1;
                        r_rst_cnt    <= '0;
                    end else if (r_sbuf_cnt != '0) begin
                        r_cfg_en     <= 1'b1;
                        r_cfg_din    <= r_sbuf[WORD_WIDTH-1];
                        r_sbuf       <= r_sbuf << 1;
                        r_sbuf_cnt   <= r_sbuf_cnt - SbW'(1);
                        r_word_ready <= (r_sbuf_cnt == SbW'(1)) && w_more;
                    end else if (w_take) begin
                        r_cfg_en     <= 1'b1;
                        r_cfg_din    <= io_bus.word_in[WORD_WIDTH-1];
                        r_sbuf       <= io_bus.word_in << 1;
                        r_sbuf_cnt   <= SbW'(WORD_WIDTH - 1);
                        r_word_ready <= (WORD_WIDTH == 1) && w_more;
                    end else begin
                        r_cfg_en     <= 1'b0;
                        r_word_ready <= 1'b1;
                    end
                end
                StFabricRst: begin
                    if (r_rst_cnt == RstW'(RST_CYCLES - 1)) begin
                        r_state   <= StDone;
                        r_le_nrst <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RstW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A frozen shift enable or ready must not look like a live shift or transfer.
    assign io_bus.config_en      = r_cfg_en & io_bus.en;
    assign io_bus.word_ready     = r_word_ready & io_bus.en;
    assign io_bus.config_data_in = r_cfg_din;
    assign io_bus.le_en          = r_le_en;
    assign io_bus.le_nrst        = r_le_nrst;
    assign io_bus.busy           = r_busy;
    assign io_bus.done           = r_done;
    assign io_bus.tail_parity    = r_tail_parity;
endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader driving a 17-bit chain model (one logic element).
module tb_config_loader;
    localparam int unsigned WW = 8;
    localparam int unsigned CL = 17;
    localparam int unsigned RC = 2;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    config_loader_if #(.WORD_WIDTH(WW)) bus ();

    config_loader #(
        .WORD_WIDTH(WW),
        .CHAIN_LEN (CL),
        .RST_CYCLES(RC)
    ) dut (
        .i_clk (clk),
        .i_nrst(nrst),
        .io_bus(bus)
    );

    // CRAM chain: head at bit 0, tail at bit 16; not affected by the controller reset.
    logic [CL-1:0] chain = 17'h12345;
    int hs_cnt = 0;
    int shift_cnt = 0;
    always @(posedge clk) begin
        if (bus.config_en) chain <= {chain[CL-2:0], bus.config_data_in};
        if (bus.config_en) shift_cnt <= shift_cnt + 1;
        if (bus.word_valid && bus.word_ready) hs_cnt <= hs_cnt + 1;
    end
    assign bus.config_data_out = chain[CL-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " reset_outputs"},
              {24'd0, bus.config_en, bus.config_data_in, bus.word_ready, bus.le_en,
               bus.le_nrst, bus.busy, bus.done, bus.tail_parity}, 32'd0);
    endtask

    // One load; cycle k means the negedge after edge Ek, E0 being the start edge.
    task automatic do_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input int gap, input int pause_at,
                           input int start_at, input int abort_at, input int exp_done,
                           input logic [CL-1:0] exp_chain);
        logic [7:0] words [3];
        logic       exp_par;
        int hs_base, sh_base, idx, gap_left, cyc, done_cyc, done_len, rst_len;
        int late_ready, pause_bad, nrst_early;
        words[0]   = w0;
        words[1]   = w1;
        words[2]   = w2;
        exp_par    = ^chain;
        hs_base    = hs_cnt;
        sh_base    = shift_cnt;
        gap_left   = gap;
        done_cyc   = -1;
        done_len   = 0;
        rst_len    = 0;
        late_ready = 0;
        pause_bad  = 0;
        nrst_early = 0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        check({tag, " busy_ready_after_start"}, {30'd0, bus.busy, bus.word_ready}, 32'd3);
        while (cyc < 200 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
            idx    = hs_cnt - hs_base;
            bus.en = !(pause_at >= 0 && cyc >= pause_at && cyc < pause_at + 3);
            bus.start = (cyc == start_at);
            #1;
            if (cyc == abort_at) begin
                nrst = 1'b0;
                bus.word_valid = 1'b0;
                #1;
                check_reset({tag, " abort"});
                @(negedge clk);
                nrst = 1'b1;
                return;
            end
            if (!bus.en && bus.config_en) pause_bad++;
            if (idx >= 3 && bus.word_ready) late_ready++;
            if (bus.le_en && !bus.le_nrst) rst_len++;
            if (bus.done) begin
                done_len++;
                if (done_cyc < 0) done_cyc = cyc;
                check({tag, " le_nrst_with_done"}, {31'd0, bus.le_nrst}, 32'd1);
            end
            if (done_cyc < 0 && bus.le_nrst) nrst_early++;
            if (idx == 1 && gap_left > 0 && bus.word_ready) begin
                bus.word_valid = 1'b0;
                gap_left--;
            end else if (idx < 3) begin
                bus.word_valid = 1'b1;
                bus.word_in    = words[idx];
            end else begin
                bus.word_valid = 1'b0;
                bus.word_in    = 8'h00;
            end
            @(negedge clk);
            cyc++;
        end
        bus.en = 1'b1;
        bus.start = 1'b0;
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " done_width"}, done_len, 1);
        check({tag, " fabric_rst_cycles"}, rst_len, RC);
        check({tag, " shifts"}, shift_cnt - sh_base, CL);
        check({tag, " handshakes"}, hs_cnt - hs_base, 3);
        check({tag, " ready_after_last_word"}, late_ready, 0);
        check({tag, " config_en_in_pause"}, pause_bad, 0);
        check({tag, " le_nrst_before_done"}, nrst_early, 0);
        check({tag, " chain"}, {15'd0, chain}, {15'd0, exp_chain});
        check({tag, " tail_parity"}, {31'd0, bus.tail_parity}, {31'd0, exp_par});
        check({tag, " idle_fabric_on"}, {29'd0, bus.busy, bus.le_en, bus.le_nrst}, 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sel;
        nrst           = 1'b0;
        bus.en         = 1'b1;
        bus.start      = 1'b0;
        bus.word_in    = 8'h00;
        bus.word_valid = 1'b0;
        #1;
        check_reset("power_on");
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("idle_after_release");

        // Mode 1, LUT 0x6996: stream 1_0110100110010110.
        do_load("load_a", 8'hB4, 8'hCB, 8'h7F, 0, -1, -1, -1, 20, 17'h16996);
        for (int s = 0; s < 16; s++) begin
            sel = s[3:0];
            check($sformatf("lut_sel_%0d", s), {31'd0, chain[s]}, {31'd0, ^sel});
        end
        repeat (2) @(negedge clk);
        // Padding bits of the last word are never shifted.
        do_load("load_pad", 8'hB4, 8'hCB, 8'h00, 0, -1, -1, -1, 20, 17'h16996);
        repeat (2) @(negedge clk);
        // Mode 0 stream with a 5-cycle starvation gap after the first word.
        do_load("load_starve", 8'h34, 8'hCB, 8'h00, 5, -1, -1, -1, 25, 17'h06996);
        repeat (2) @(negedge clk);
        // Reload displaces the mode-0 stream (parity 0); en pause and stray start.
        do_load("load_pause", 8'hB4, 8'hCB, 8'h7F, 0, 5, 10, -1, 23, 17'h16996);
        repeat (2) @(negedge clk);
        do_load("load_abort", 8'h34, 8'hCB, 8'h00, 0, -1, -1, 10, 0, 17'h00000);
        repeat (2) @(negedge clk);
        check_reset("after_abort");
        do_load("load_fresh", 8'h34, 8'hCB, 8'h00, 0, -1, -1, -1, 20, 17'h06996);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
